// File: rtl/switch_debounce_combine.sv
// switch_debounce_combine
//   Debounces N_CH raw switch inputs, combines the debounced levels with a
//   selectable logic function (AND / OR / XOR / majority) and flags rising
//   and falling transitions of the combined result.
//
//   Optional build macro: SWITCH_SYNC_EN
//     defined   -> every in_sw bit passes a two-flop synchroniser (+2 cycles)
//     undefined -> in_sw is sampled directly by the debounce counters
//
//   All state is cleared by the synchronous active-high rst.
module switch_debounce_combine #(
  parameter int N_CH       = 2,
  parameter int DEB_CYCLES = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] in_sw,
  input  logic [1:0]      mode,
  output logic [N_CH-1:0] sw_stable,
  output logic            out,
  output logic            out_rise,
  output logic            out_fall
);

  // Counter wide enough to hold 0..DEB_CYCLES; it only ever reaches
  // DEB_CYCLES-1 because acceptance happens on that value.
  localparam int CW = $clog2(DEB_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ZERO = CW'(0);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  // Mode encodings of the combine function.
  localparam logic [1:0] MODE_AND = 2'b00;
  localparam logic [1:0] MODE_OR  = 2'b01;
  localparam logic [1:0] MODE_XOR = 2'b10;
  localparam logic [1:0] MODE_MAJ = 2'b11;

  // ---------------------------------------------------------------------
  // Helper functions
  // ---------------------------------------------------------------------

  // Number of set bits in the debounced vector (N_CH <= 16 fits in 5 bits).
  function automatic logic [5:0] popcount_fn(input logic [N_CH-1:0] bits);
    logic [5:0] acc;
    acc = 6'd0;
    for (int i = 0; i < N_CH; i++) begin
      acc = acc + {5'd0, bits[i]};
    end
    return acc;
  endfunction

  // Odd parity of the debounced vector.
  function automatic logic parity_fn(input logic [N_CH-1:0] bits);
    logic acc;
    acc = 1'b0;
    for (int i = 0; i < N_CH; i++) begin
      acc = acc ^ bits[i];
    end
    return acc;
  endfunction

  // Strict majority: more ones than zeros; an exact tie resolves to 0.
  function automatic logic majority_fn(input logic [N_CH-1:0] bits);
    logic [6:0] twice;
    twice = {popcount_fn(bits), 1'b0};
    return (twice > 7'(N_CH));
  endfunction

  // Combined result for a debounced vector under a given mode.
  function automatic logic combine_fn(input logic [N_CH-1:0] bits,
                                      input logic [1:0]      sel);
    logic res;
    case (sel)
      MODE_AND: res = &bits;
      MODE_OR:  res = |bits;
      MODE_XOR: res = parity_fn(bits);
      MODE_MAJ: res = majority_fn(bits);
      default:  res = 1'b0;
    endcase
    return res;
  endfunction

  // ---------------------------------------------------------------------
  // Input sampling (optional two-flop synchroniser)
  // ---------------------------------------------------------------------
  logic [N_CH-1:0] sampled_s;

`ifdef SWITCH_SYNC_EN
  logic [N_CH-1:0] meta_r;
  logic [N_CH-1:0] sync_r;

  // Two-stage synchroniser bringing the asynchronous switches into clk.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta_r <= {N_CH{1'b0}};
      sync_r <= {N_CH{1'b0}};
    end else begin
      meta_r <= in_sw;
      sync_r <= meta_r;
    end
  end

  assign sampled_s = sync_r;
`else
  assign sampled_s = in_sw;
`endif

  // ---------------------------------------------------------------------
  // Per-channel debounce
  // ---------------------------------------------------------------------
  logic [CW-1:0]   cnt_r [N_CH];
  logic [N_CH-1:0] stable_r;

  // Each channel counts consecutive samples that disagree with its stable
  // level; agreement clears the count, and the DEB_CYCLES-th disagreeing
  // sample flips the stable level.
  always_ff @(posedge clk) begin
    if (rst) begin
      stable_r <= {N_CH{1'b0}};
      for (int i = 0; i < N_CH; i++) begin
        cnt_r[i] <= CNT_ZERO;
      end
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        if (sampled_s[i] == stable_r[i]) begin
          cnt_r[i] <= CNT_ZERO;
        end else if (cnt_r[i] == CNT_LAST) begin
          stable_r[i] <= sampled_s[i];
          cnt_r[i]    <= CNT_ZERO;
        end else begin
          cnt_r[i] <= cnt_r[i] + CNT_ONE;
        end
      end
    end
  end

  assign sw_stable = stable_r;

  // ---------------------------------------------------------------------
  // Combine and edge detection
  // ---------------------------------------------------------------------
  logic comb_s;
  logic rise_s;
  logic fall_s;
  logic out_r;
  logic rise_r;
  logic fall_r;

  // Next combined value from the current debounced levels and mode; mode
  // acts directly so a mode change never waits for re-debouncing.
  always_comb begin
    comb_s = 1'b0;
    rise_s = 1'b0;
    fall_s = 1'b0;
    comb_s = combine_fn(stable_r, mode);
    if (comb_s != out_r) begin
      rise_s = comb_s;
      fall_s = ~comb_s;
    end else begin
      rise_s = 1'b0;
      fall_s = 1'b0;
    end
  end

  // Result and its edge pulses are registered together so a pulse lines up
  // with the first cycle the new result is visible.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_r  <= 1'b0;
      rise_r <= 1'b0;
      fall_r <= 1'b0;
    end else begin
      out_r  <= comb_s;
      rise_r <= rise_s;
      fall_r <= fall_s;
    end
  end

  assign out      = out_r;
  assign out_rise = rise_r;
  assign out_fall = fall_r;

endmodule

// File: tb/tb_switch_debounce_combine.sv
// Self-checking bench for switch_debounce_combine (N_CH=2, DEB_CYCLES=4).
// Expected values come from a behavioural model: a delay line for the
// optional synchroniser, a window of recent samples per channel and the
// combine rules evaluated with plain arithmetic.
module tb_switch_debounce_combine;

  localparam int N   = 2;
  localparam int DEB = 4;
`ifdef SWITCH_SYNC_EN
  localparam int SYNC = 2;
`else
  localparam int SYNC = 0;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] in_sw;
  logic [1:0]   mode;
  logic [N-1:0] sw_stable;
  logic         out;
  logic         out_rise;
  logic         out_fall;

  int n_checks = 0;
  int n_errors = 0;

  switch_debounce_combine #(.N_CH(N), .DEB_CYCLES(DEB)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_sw     (in_sw),
    .mode      (mode),
    .sw_stable (sw_stable),
    .out       (out),
    .out_rise  (out_rise),
    .out_fall  (out_fall)
  );

  always #5 clk = ~clk;

  // ---------------- reference model state ----------------
  logic [N-1:0] pipe_q[$];   // synchroniser delay line
  logic [N-1:0] hist_q[$];   // most recent DEB samples since reset
  logic [N-1:0] m_stable;
  logic         m_out, m_rise, m_fall;

  function automatic logic model_combine(input logic [N-1:0] s, input logic [1:0] md);
    int ones;
    ones = $countones(s);
    case (md)
      2'd0:    return (ones == N);
      2'd1:    return (ones > 0);
      2'd2:    return (ones % 2) == 1;
      default: return (2 * ones) > N;
    endcase
  endfunction

  task automatic model_reset();
    pipe_q = {};
    for (int k = 0; k < SYNC; k++) pipe_q.push_back('0);
    hist_q   = {};
    m_stable = '0;
    m_out    = 1'b0;
    m_rise   = 1'b0;
    m_fall   = 1'b0;
  endtask

  // Advance the model by one rising edge using the inputs present there.
  task automatic model_edge();
    logic [N-1:0] samp;
    logic         nout;
    bit           all_diff;
    if (rst) begin
      model_reset();
    end else begin
      if (SYNC == 0) begin
        samp = in_sw;
      end else begin
        samp = pipe_q.pop_front();
        pipe_q.push_back(in_sw);
      end
      nout   = model_combine(m_stable, mode);
      m_rise = nout && !m_out;
      m_fall = !nout && m_out;
      m_out  = nout;
      hist_q.push_back(samp);
      if (hist_q.size() > DEB) void'(hist_q.pop_front());
      // A level is accepted once the last DEB samples all disagree with it.
      for (int ch = 0; ch < N; ch++) begin
        if (hist_q.size() == DEB) begin
          all_diff = 1'b1;
          foreach (hist_q[k]) if (hist_q[k][ch] == m_stable[ch]) all_diff = 1'b0;
          if (all_diff) m_stable[ch] = ~m_stable[ch];
        end
      end
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // One clock: model follows the edge, outputs compared on the falling edge.
  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check("sw_stable", 32'(sw_stable), 32'(m_stable));
    check("out",       32'(out),       32'(m_out));
    check("out_rise",  32'(out_rise),  32'(m_rise));
    check("out_fall",  32'(out_fall),  32'(m_fall));
    if (out_rise && out_fall) check("rise_fall_excl", 32'd1, 32'd0);
  endtask

  // Count edges until sw_stable reaches target (bounded) and check latency.
  task automatic measure(input string tag, input logic [N-1:0] target);
    int k;
    k = 0;
    do begin
      step();
      k++;
    end while (sw_stable !== target && k < 60);
    check(tag, 32'(k), 32'(SYNC + DEB));
  endtask

  initial begin
    rst   = 1'b1;
    in_sw = '0;
    mode  = 2'b00;
    model_reset();

    // Reset for two cycles, then idle with all-zero inputs.
    step(); step();
    rst = 1'b0;
    repeat (20) step();
    check("idle_stable", 32'(sw_stable), 32'd0);

    // Both channels rise together under AND.
    in_sw = 2'b11;
    measure("lat_11", 2'b11);
    step();
    check("and_rise", 32'(out_rise), 32'd1);
    step();

    // AND truth table through the debounced path.
    for (int v = 0; v < 4; v++) begin
      in_sw = v[N-1:0];
      repeat (SYNC + DEB + 3) step();
      check("and_tt", 32'(out), (v == 3) ? 32'd1 : 32'd0);
    end

    // Bounces shorter than DEB never change anything.
    in_sw = 2'b00;
    repeat (12) step();
    for (int r = 0; r < 5; r++) begin
      in_sw = 2'b01; repeat (3) step();
      in_sw = 2'b00; repeat (3) step();
    end
    check("bounce_stable", 32'(sw_stable), 32'd0);

    // Mode stepping with sw_stable = 01.
    in_sw = 2'b01;
    repeat (SYNC + DEB + 2) step();
    for (int md = 0; md < 4; md++) begin
      mode = md[1:0];
      repeat (3) step();
    end

    // Reset in the middle of a count discards it.
    mode  = 2'b00;
    in_sw = 2'b00;
    repeat (12) step();
    in_sw = 2'b11;
    repeat (3) step();
    rst = 1'b1;
    step();
    check("rst_out", 32'({sw_stable, out, out_rise, out_fall}), 32'd0);
    rst = 1'b0;
    measure("lat_after_rst", 2'b11);

    // Randomized bouncing inputs, mode changes and occasional resets.
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(3, 0) == 0) in_sw = N'($urandom);
      if ($urandom_range(15, 0) == 0) mode = 2'($urandom);
      rst = ($urandom_range(299, 0) == 0);
      step();
    end
    rst = 1'b0;
    step();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/switch_debounce_combine.md
SWITCH_DEBOUNCE_COMBINE -- requirements
Module: switch_debounce_combine

Interface
REQ-001 Parameter N_CH, default 2, number of switch channels, legal range 1..16.
REQ-002 Parameter DEB_CYCLES, default 4, consecutive sampled cycles an input must hold a new level before acceptance, legal range 1..65535.
REQ-003 Port clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port rst  input  1  reset, synchronous, active-high.
REQ-005 Port in_sw  input  N_CH  raw switch levels, asynchronous to clk, may bounce.
REQ-006 Port mode  input  2  combine function: 00 AND, 01 OR, 10 XOR, 11 majority.
REQ-007 Port sw_stable  output  N_CH  debounced per-channel levels, registered.
REQ-008 Port out  output  1  combined result of sw_stable under mode, registered.
REQ-009 Port out_rise  output  1  single-cycle pulse when out goes 0->1.
REQ-010 Port out_fall  output  1  single-cycle pulse when out goes 1->0.

Function
REQ-011 Each channel SHALL keep an independent debounce counter of width ceil(log2(DEB_CYCLES+1)) and a stable bit.
REQ-012 Per channel, sampled level equal to stable bit SHALL clear the counter.
REQ-013 Per channel, sampled level different from stable bit SHALL increment the counter; on the edge where counter equals DEB_CYCLES-1, stable bit SHALL take the sampled level and counter SHALL clear.
REQ-014 Any return to the stable level before acceptance SHALL clear the counter; a bounce shorter than DEB_CYCLES cycles SHALL never change sw_stable.
REQ-015 DEB_CYCLES=1 SHALL accept a new level on the first sampled edge; the counter SHALL never wrap or exceed DEB_CYCLES-1.
REQ-016 Latency from sampled-level change to sw_stable change SHALL be exactly DEB_CYCLES cycles (plus synchroniser latency, REQ-024).
REQ-017 out SHALL be registered from current sw_stable and mode: AND = all bits 1; OR = any bit 1; XOR = odd parity; majority = 2*popcount > N_CH (ties 0).
REQ-018 out SHALL update exactly one cycle after sw_stable or mode changes; mode changes SHALL take effect without re-debouncing.
REQ-019 out_rise/out_fall SHALL be registered alongside out, high for exactly the first cycle in which the new out value is visible, never both at once.
REQ-020 Simultaneous channel acceptances on one edge SHALL be combined as one sw_stable update; only a net change of out SHALL pulse.

Reset
REQ-021 While rst is high at a rising edge: all counters, stable bits and synchroniser flops SHALL clear to 0; sw_stable=0, out=0, out_rise=0, out_fall=0 from the next cycle.
REQ-022 Reset asserted mid-count SHALL discard partial counts; after release each channel SHALL require the full latency again.
REQ-023 No out_rise/out_fall pulse SHALL be generated by reset or by the first cycle after release (all modes evaluate 0 for all-zero inputs).

Configuration
REQ-024 Macro SWITCH_SYNC_EN defined: each in_sw bit SHALL pass through a two-flop synchroniser before debounce, adding exactly 2 cycles of latency; undefined: in_sw SHALL be sampled directly by the debounce logic with no added latency.

Verification (N_CH=2, DEB_CYCLES=4, SWITCH_SYNC_EN defined unless stated)
REQ-025 rst=1 two cycles, in_sw=00, mode=00 -> sw_stable=00, out=0, no pulses for 20 cycles after release.
REQ-026 mode=00, in_sw 00->11 held -> sw_stable=11 exactly 6 cycles after change, out=1 and out_rise=1 for one cycle 7 cycles after change; truth table 00/01/10/11 under AND gives out 0/0/0/1.
REQ-027 in_sw[0] pulsed high 3 cycles then low, repeated 5 times -> sw_stable, out unchanged, no pulses.
REQ-028 sw_stable=01 held, mode stepped 00,01,10,11 every 3 cycles -> out 0,1,1,0 each one cycle after mode change; out_rise on 00->01, out_fall on 10->11.
REQ-029 in_sw=11 held 3 cycles, rst pulsed one cycle, in_sw still 11 -> all outputs 0 cycle after rst, sw_stable=11 exactly 6 cycles after rst release.
REQ-030 SWITCH_SYNC_EN undefined, in_sw 00->10 held -> sw_stable=10 exactly 4 cycles after change; mode=01 gives out=1 one cycle later.
